// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares one synchronous single-port RAM between the
// Wishbone CPU slave port and the VGA line-fetch port. Video has priority.
module vga_fb_arbiter #(
    parameter int adr_width = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    input  logic                 vid_req,
    input  logic [adr_width-1:0] vid_adr,
    output logic [31:0]          vid_dat,
    output logic                 vid_ack,
    output logic [adr_width-1:0] ram_adr,
    output logic                 ram_we,
    output logic [3:0]           ram_be,
    output logic [31:0]          ram_wdat,
    input  logic [31:0]          ram_rdat
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] VID_ADDR = 3'd1;
    localparam logic [2:0] VID_DATA = 3'd2;
    localparam logic [2:0] CPU_ADDR = 3'd3;
    localparam logic [2:0] CPU_DATA = 3'd4;

    localparam logic LG_CPU = 1'b0;
    localparam logic LG_VID = 1'b1;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_grant;
    logic       cpu_rq;
    logic       vid_rq;
    logic       cpu_el;
    logic       vid_el;
    logic       decide;
    logic       grant_vid;
    logic       grant_cpu;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

    assign cpu_rq = wb_cyc_i & wb_stb_i;
    assign vid_rq = vid_req;

    // The requester being acked still holds its request, so it is masked
    // in its own DATA state to stop it from being regranted immediately.
    assign cpu_el = cpu_rq & (state != CPU_DATA);
    assign vid_el = vid_rq & (state != VID_DATA);

    assign decide    = (state == IDLE) | (state == VID_DATA) | (state == CPU_DATA);
    assign grant_vid = decide & vid_el & (~cpu_el | (last_grant == LG_CPU));
    assign grant_cpu = decide & cpu_el & ~grant_vid;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            VID_ADDR: state_nxt = VID_DATA;
            CPU_ADDR: state_nxt = CPU_DATA;
            default: begin
                if (grant_vid)
                    state_nxt = VID_ADDR;
                else if (grant_cpu)
                    state_nxt = CPU_ADDR;
                else
                    state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= LG_CPU;
            ram_adr    <= '0;
            ram_we     <= 1'b0;
            ram_be     <= 4'b0000;
            ram_wdat   <= 32'h0;
        end else begin
            state  <= state_nxt;
            // Write strobes live for exactly the one CPU_ADDR cycle.
            ram_we <= 1'b0;
            ram_be <= 4'b0000;
            if (grant_vid) begin
                ram_adr    <= vid_adr;
                last_grant <= LG_VID;
            end else if (grant_cpu) begin
                ram_adr    <= wb_adr_i[adr_width+1:2];
                last_grant <= LG_CPU;
                if (wb_we_i) begin
                    ram_we   <= 1'b1;
                    ram_be   <= wb_sel_i;
                    ram_wdat <= wb_dat_i;
                end
            end
        end
    end

    assign vid_ack  = (state == VID_DATA);
    assign wb_ack_o = (state == CPU_DATA);
    assign vid_dat  = vid_ack  ? ram_rdat : 32'h0;
    assign wb_dat_o = wb_ack_o ? ram_rdat : 32'h0;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares the single-port framebuffer RAM between the LM32 Wishbone data bus (CPU pixel writes/readback) and the VGA scanout fetch port that feeds red/green/blue/rgbinfo. Sits between the Wishbone interconnect slave slot, the VGA timing/line-fetch unit, and the framebuffer block RAM (synchronous read, 1-cycle latency). Video has priority, with an alternation rule that guarantees the CPU forward progress.

## Interface
- adr_width, 13, framebuffer word-address width (32-bit words)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address; word address = wb_adr_i[adr_width+1:2], other bits ignored
- wb_sel_i  in  4  byte lanes for writes
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_ack_o  out  1  one-cycle acknowledge
- vid_req  in  1  video fetch request, level, held until vid_ack
- vid_adr  in  adr_width  video word address, stable while vid_req=1
- vid_dat  out  32  fetched word, valid while vid_ack=1
- vid_ack  out  1  one-cycle acknowledge
- ram_adr  out  adr_width  RAM word address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_be  out  4  RAM byte enables (registered; 0 on reads)
- ram_wdat  out  32  RAM write data (registered)
- ram_rdat  in  32  RAM read data, valid one cycle after address sampled

## Operation
- cpu_rq = wb_cyc_i & wb_stb_i; vid_rq = vid_req.
- States: IDLE, VID_ADDR, VID_DATA, CPU_ADDR, CPU_DATA.
- Arbitration performed in IDLE, VID_DATA and CPU_DATA. In VID_DATA vid_rq is masked; in CPU_DATA cpu_rq is masked (requester being acked still holds its request that cycle).
- Grant rule: only one eligible -> grant it. Both eligible -> video, unless last_grant = video, then CPU. Neither -> IDLE.
- Entering VID_ADDR: ram_adr <= vid_adr, ram_we <= 0, ram_be <= 0; last_grant <= video.
- Entering CPU_ADDR: ram_adr <= word address; if wb_we_i: ram_we <= 1, ram_be <= wb_sel_i, ram_wdat <= wb_dat_i; else ram_we <= 0, ram_be <= 0. last_grant <= CPU.
- ram_we/ram_be cleared on every transition out of CPU_ADDR (write lasts exactly one cycle).
- VID_DATA: vid_ack=1, vid_dat=ram_rdat. CPU_DATA: wb_ack_o=1, wb_dat_o=ram_rdat (don't-care on writes). Acks decoded from state register; dat outputs 0 outside DATA states.
- A granted transaction always completes: stb/vid_req dropping in ADDR state does not cancel it; ack still issued.
- wb_stb_i with wb_cyc_i=0 is ignored.

## Timing
- Reset (rst=0, async): state IDLE, last_grant = CPU, ram_adr=0, ram_we=0, ram_be=0, ram_wdat=0, wb_ack_o=0, vid_ack=0, wb_dat_o=0, vid_dat=0. Reset mid-transaction aborts with no ack; a write in CPU_ADDR is cut off by ram_we clearing asynchronously.
- Request seen from IDLE at edge N -> ADDR during cycle N..N+1 -> ack during cycle N+1..N+2. Latency from IDLE: ack 2 cycles after grant edge.
- Back-to-back alternating requesters: one access per 2 cycles (DATA -> next ADDR directly).
- Same requester back-to-back: 3 cycles per access (masked in own DATA state, granted via IDLE... or next DATA).
- Worst-case video wait with CPU contending: 4 cycles from vid_req to vid_ack (one CPU access in progress, then video).
- CPU never waits more than one video access once pending at a decision point.

## Test plan
- Reset: hold rst=0 with vid_req=1, cpu write pending -> all outputs 0, no ack; release -> video granted first (last_grant=CPU).
- CPU write adr 0x0000_0010, sel 4'b0011, dat 0xDEADBEEF -> ram_adr=4, ram_we=1 one cycle, ram_be=4'b0011, wb_ack_o one cycle 2 edges after grant.
- CPU read adr 0x10 with ram model holding 0x12345678 -> wb_dat_o=0x12345678 with wb_ack_o, ram_we=0 throughout.
- Video continuous vid_req, vid_adr 0..7, CPU stb held -> grants alternate V,C,V,C; each ack one cycle; video max wait 4 cycles.
- Both idle then simultaneous requests after a video access -> CPU granted first.
- Assert rst=0 while in CPU_ADDR of a write -> ram_we drops immediately, no wb_ack_o; after release, IDLE with next grant per reset priority.
